stp_watch_core: RTL and testbench
=================================

Name: stp_watch_core

Overview:
Parametrised stopwatch core. A start/pause/clear FSM drives a clock prescaler and a cascaded sub-second/second/minute/hour counter chain. Adds three features: lap capture, saturating overflow detection and optional BCD output. Sits between the stopwatch button debouncers and the display mux. Replaces the fixed 1 kHz seconds-only counter.

Parameters:
CLK_HZ, 1000, input clock frequency in Hz
TICK_HZ, 100, sub-second resolution in Hz; DIV = CLK_HZ/TICK_HZ must be an integer >= 2; TICK_HZ <= 100
HR_MAX, 99, largest hour value (<= 99)
LAP_CNT_W, 4, width of the lap counter

Ports:
CLK  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  global count enable; when 0 the prescaler holds and no ticks occur
start_stop  in  1  single-cycle pulse; toggles run/pause
clear  in  1  single-cycle pulse; zeroes the time (ignored in RUN)
lap  in  1  single-cycle pulse; captures a lap (RUN only)
running  out  1  high in RUN state
sub_sec  out  8  sub-second count, 0..TICK_HZ-1
seconds  out  8  0..59
minutes  out  8  0..59
hours  out  8  0..HR_MAX
tick_sub  out  1  one-cycle pulse when sub_sec advances
tick_sec  out  1  one-cycle pulse when seconds advances (includes wrap to 0)
overflow  out  1  sticky, set on saturation
lap_sub, lap_sec, lap_min, lap_hr  out  8 each  captured lap time
lap_valid  out  1  one-cycle pulse, the cycle after a capture
lap_count  out  LAP_CNT_W  number of laps taken; wraps modulo 2^LAP_CNT_W

Behaviour:
- Reset: all outputs, prescaler and state go to 0/IDLE, asynchronously.
- FSM states: IDLE (time is zero, stopped), RUN, PAUSE.
  - IDLE --start_stop--> RUN
  - RUN --start_stop--> PAUSE
  - PAUSE --start_stop--> RUN
  - PAUSE --clear--> IDLE
  - IDLE --clear--> IDLE
  - clear in RUN is ignored.
  - clear and start_stop together in IDLE/PAUSE: clear wins, result is IDLE.
  - RUN --overflow--> PAUSE.
- Entering IDLE zeroes the prescaler, time fields, lap fields, lap_count and overflow.
- Prescaler:
  - Increments only in RUN with en=1.
  - At DIV-1 it wraps to 0 and produces an internal tick in the same cycle.
  - It holds its value in PAUSE, so no fraction of a tick is lost on resume.
- Cascade on tick, all fields registered:
  - sub_sec increments; it wraps at TICK_HZ-1 and carries into seconds.
  - seconds wraps at 59 and carries into minutes.
  - minutes wraps at 59 and carries into hours.
  - tick_sub/tick_sec are registered and align with the cycle the new value appears.
- Saturation: a tick at HR_MAX:59:59.(TICK_HZ-1) leaves the value unchanged, sets overflow and forces PAUSE. Further start_stop in that state is ignored until clear.
- Latency: first sub_sec increment appears DIV cycles after running rises (given en=1 throughout).
- Lap:
  - A lap in RUN copies the current displayed fields into lap_* registers; if a tick occurs in the same cycle, the pre-increment value is captured.
  - lap_count increments on capture; lap_valid pulses the next cycle.
  - lap in IDLE/PAUSE is ignored.
  - lap with start_stop in RUN: the capture happens and the state moves to PAUSE.

Optional Feature:
STP_BCD_OUT_EN
- Defined: sub_sec/seconds/minutes/hours and lap_* carry packed two-digit BCD (e.g. 59 = 8'h59). Counters are implemented as BCD digit pairs. Wrap/carry points and all timing are identical.
- Undefined: plain binary values.

Test Plan:
- Test parameters: CLK_HZ=1000, TICK_HZ=100 unless stated.
- Reset, pulse start_stop, hold en=1 for 1000 cycles after running rises -> seconds=1, sub_sec=0, exactly one tick_sec, 100 tick_sub pulses.
- Run 25 cycles, pulse start_stop, wait 500 cycles, resume for 5 cycles -> sub_sec=3; the prescaler retains its count across the pause, so the third tick lands exactly 30 run-cycles in.
- Pulse clear in RUN -> no change, running stays 1. Pause, then pulse clear with start_stop -> IDLE, all fields 0, running=0.
- CLK_HZ=2, TICK_HZ=1, HR_MAX=1: run until 1:59:59 and apply one more tick -> value held at 1:59:59, overflow=1, running=0. A further start_stop is ignored; clear -> all 0, overflow=0.
- Lap asserted on the cycle of the tick taking 0:00:59.99 to 0:01:00.00 -> lap_sec=59, lap_sub=99, lap_min=0, lap_valid one cycle later, lap_count=1. Apply 16 laps with LAP_CNT_W=4 -> lap_count=0.
- With STP_BCD_OUT_EN defined, run to 0:00:12.34 -> seconds=8'h12, sub_sec=8'h34. Run to minute rollover -> minutes=8'h01, seconds=8'h00.

Source files
------------

// File: rtl/stp_watch_core.sv
// stp_watch_core: stopwatch core with a start/pause/clear FSM, a clock
// prescaler and a cascaded sub-second/second/minute/hour counter chain.
// The core also provides lap capture and saturating overflow detection.
// Build macro STP_BCD_OUT_EN: when defined, the time and lap fields are
// packed two-digit BCD. When undefined, they are plain binary values.
module stp_watch_core #(
  parameter int CLK_HZ    = 1000,
  parameter int TICK_HZ   = 100,
  parameter int HR_MAX    = 99,
  parameter int LAP_CNT_W = 4
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start_stop,
  input  logic                 clear,
  input  logic                 lap,
  output logic                 running,
  output logic [7:0]           sub_sec,
  output logic [7:0]           seconds,
  output logic [7:0]           minutes,
  output logic [7:0]           hours,
  output logic                 tick_sub,
  output logic                 tick_sec,
  output logic                 overflow,
  output logic [7:0]           lap_sub,
  output logic [7:0]           lap_sec,
  output logic [7:0]           lap_min,
  output logic [7:0]           lap_hr,
  output logic                 lap_valid,
  output logic [LAP_CNT_W-1:0] lap_count
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Encode a small integer in the field representation (binary or BCD).
  function automatic logic [7:0] fld_enc(input int v);
`ifdef STP_BCD_OUT_EN
    fld_enc = 8'(((v / 10) % 10) * 16 + (v % 10));
`else
    fld_enc = 8'(v);
`endif
  endfunction

  // Advance a field by one. The caller handles the wrap back to zero.
  function automatic logic [7:0] fld_inc(input logic [7:0] v);
`ifdef STP_BCD_OUT_EN
    if (v[3:0] == 4'd9) fld_inc = {v[7:4] + 4'd1, 4'd0};
    else                fld_inc = {v[7:4], v[3:0] + 4'd1};
`else
    fld_inc = v + 8'd1;
`endif
  endfunction

  localparam logic [7:0] SUB_TOP = fld_enc(TICK_HZ - 1);
  localparam logic [7:0] MS_TOP  = fld_enc(59);
  localparam logic [7:0] HR_TOP  = fld_enc(HR_MAX);

  logic [1:0]           state_reg, state_next;
  logic [PW-1:0]        presc_reg;
  logic [7:0]           sub_reg, sec_reg, min_reg, hr_reg;
  logic                 tick_sub_reg, tick_sec_reg, ovf_reg;
  logic [7:0]           lap_sub_reg, lap_sec_reg, lap_min_reg, lap_hr_reg;
  logic                 lap_valid_reg;
  logic [LAP_CNT_W-1:0] lap_count_reg;

  logic is_run, tick, advance, sub_wrap, sec_wrap, min_wrap, at_max;
  logic do_clear, lap_take;

  assign is_run   = (state_reg == ST_RUN);
  assign tick     = is_run && en && (presc_reg == PW'(DIV - 1));
  assign sub_wrap = (sub_reg == SUB_TOP);
  assign sec_wrap = (sec_reg == MS_TOP);
  assign min_wrap = (min_reg == MS_TOP);
  assign at_max   = sub_wrap && sec_wrap && min_wrap && (hr_reg == HR_TOP);
  assign advance  = tick && !at_max;
  // A clear pulse is honoured only outside RUN. It always lands in IDLE.
  assign do_clear = clear && !is_run;
  assign lap_take = lap && is_run;

  // Next-state logic: clear beats start_stop, and saturation forces PAUSE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!clear && start_stop) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (start_stop || (tick && at_max)) state_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clear)                        state_next = ST_IDLE;
        else if (start_stop && !ovf_reg) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Prescaler: counts only while running and enabled, and holds in PAUSE.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst)                presc_reg <= '0;
    else if (do_clear)      presc_reg <= '0;
    else if (is_run && en)  presc_reg <= tick ? '0 : presc_reg + PW'(1);
  end

  // Time cascade, aligned tick strobes and sticky saturation flag.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sub_reg      <= '0;
      sec_reg      <= '0;
      min_reg      <= '0;
      hr_reg       <= '0;
      tick_sub_reg <= 1'b0;
      tick_sec_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else if (do_clear) begin
      sub_reg      <= '0;
      sec_reg      <= '0;
      min_reg      <= '0;
      hr_reg       <= '0;
      tick_sub_reg <= 1'b0;
      tick_sec_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      tick_sub_reg <= advance;
      tick_sec_reg <= advance && sub_wrap;
      if (tick && at_max) ovf_reg <= 1'b1;
      if (advance) begin
        sub_reg <= sub_wrap ? '0 : fld_inc(sub_reg);
        if (sub_wrap) begin
          sec_reg <= sec_wrap ? '0 : fld_inc(sec_reg);
          if (sec_wrap) begin
            min_reg <= min_wrap ? '0 : fld_inc(min_reg);
            if (min_wrap) hr_reg <= fld_inc(hr_reg);
          end
        end
      end
    end
  end

  // Lap capture: snapshot the displayed (pre-tick) value and pulse valid next cycle.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      lap_sub_reg   <= '0;
      lap_sec_reg   <= '0;
      lap_min_reg   <= '0;
      lap_hr_reg    <= '0;
      lap_valid_reg <= 1'b0;
      lap_count_reg <= '0;
    end else if (do_clear) begin
      lap_sub_reg   <= '0;
      lap_sec_reg   <= '0;
      lap_min_reg   <= '0;
      lap_hr_reg    <= '0;
      lap_valid_reg <= 1'b0;
      lap_count_reg <= '0;
    end else begin
      lap_valid_reg <= lap_take;
      if (lap_take) begin
        lap_sub_reg   <= sub_reg;
        lap_sec_reg   <= sec_reg;
        lap_min_reg   <= min_reg;
        lap_hr_reg    <= hr_reg;
        lap_count_reg <= lap_count_reg + LAP_CNT_W'(1);
      end
    end
  end

  assign running   = is_run;
  assign sub_sec   = sub_reg;
  assign seconds   = sec_reg;
  assign minutes   = min_reg;
  assign hours     = hr_reg;
  assign tick_sub  = tick_sub_reg;
  assign tick_sec  = tick_sec_reg;
  assign overflow  = ovf_reg;
  assign lap_sub   = lap_sub_reg;
  assign lap_sec   = lap_sec_reg;
  assign lap_min   = lap_min_reg;
  assign lap_hr    = lap_hr_reg;
  assign lap_valid = lap_valid_reg;
  assign lap_count = lap_count_reg;

endmodule

// File: tb/tb_stp_watch_core.sv
// tb_stp_watch_core: drives three stopwatch configurations at once.
// Instance 0 uses 1000 Hz / 100 Hz. Instance 1 uses 2 Hz / 1 Hz with HR_MAX=1,
// which is the saturation configuration. Instance 2 uses 200 Hz / 100 Hz and
// serves as a short-run lap configuration. Elapsed time is modelled as a plain
// tick count, and the fields are derived from it arithmetically.
module tb_stp_watch_core;

  localparam int N = 3;

  function automatic int p_thz(input int i); return (i == 1) ? 1 : 100; endfunction
  function automatic int p_div(input int i); return (i == 0) ? 10 : 2;  endfunction
  function automatic int p_hr(input int i);  return (i == 1) ? 1 : 99;  endfunction

  typedef struct packed {
    logic        run;
    logic        ovf;
    logic [31:0] tm;
    logic        tsub;
    logic        tsec;
    logic        lv;
    logic [3:0]  lcnt;
    logic [31:0] laps;
  } status_t;

  typedef struct packed {
    logic [7:0]  inst;
    logic [31:0] tm;
  } lap_t;

  logic clk = 1'b0;
  logic rst;
  logic en [N];
  logic ss [N];
  logic clr [N];
  logic lp [N];
  logic       run_o [N];
  logic [7:0] sub_o [N];
  logic [7:0] sec_o [N];
  logic [7:0] min_o [N];
  logic [7:0] hr_o [N];
  logic       tsub_o [N];
  logic       tsec_o [N];
  logic       ovf_o [N];
  logic [7:0] lsub_o [N];
  logic [7:0] lsec_o [N];
  logic [7:0] lmin_o [N];
  logic [7:0] lhr_o [N];
  logic       lv_o [N];
  logic [3:0] lcnt_o [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    stp_watch_core #(
      .CLK_HZ(p_div(gi) * p_thz(gi)), .TICK_HZ(p_thz(gi)), .HR_MAX(p_hr(gi)), .LAP_CNT_W(4)
    ) u_dut (
      .CLK(clk), .rst(rst), .en(en[gi]), .start_stop(ss[gi]), .clear(clr[gi]), .lap(lp[gi]),
      .running(run_o[gi]), .sub_sec(sub_o[gi]), .seconds(sec_o[gi]), .minutes(min_o[gi]),
      .hours(hr_o[gi]), .tick_sub(tsub_o[gi]), .tick_sec(tsec_o[gi]), .overflow(ovf_o[gi]),
      .lap_sub(lsub_o[gi]), .lap_sec(lsec_o[gi]), .lap_min(lmin_o[gi]), .lap_hr(lhr_o[gi]),
      .lap_valid(lv_o[gi]), .lap_count(lcnt_o[gi])
    );
  end

  // Reference model state: elapsed ticks, run-cycle fraction, mode, laps.
  int m_t [N];
  int m_frac [N];
  int m_mode [N];   // 0 stopped-at-zero, 1 running, 2 paused
  int m_lapn [N];
  int m_lap [N];
  bit m_ovf [N];

  status_t sq[$];
  lap_t    lq[$];
  int n_chk = 0;
  int n_fail = 0;
  int cnt_tsub [N];
  int cnt_tsec [N];

  function automatic logic [7:0] enc(input int v);
`ifdef STP_BCD_OUT_EN
    return 8'((v / 10) * 16 + (v % 10));
`else
    return 8'(v);
`endif
  endfunction

  function automatic logic [31:0] fields(input int t, input int thz);
    return {enc(t % thz), enc((t / thz) % 60), enc((t / (thz * 60)) % 60), enc(t / (thz * 3600))};
  endfunction

  // Predict the effect of the coming clock edge for instance i.
  function automatic void model_step(input int i);
    status_t s;
    lap_t    le;
    int      maxt;
    int      prev;
    bit      run, tick_now, sat, tsub, tsec, lv;
    prev = m_mode[i];
    run  = (prev == 1);
    maxt = (p_hr(i) + 1) * 3600 * p_thz(i) - 1;
    tick_now = run && en[i] && (m_frac[i] == p_div(i) - 1);
    sat = 0; tsub = 0; tsec = 0; lv = 0;
    if (run && lp[i]) begin
      m_lap[i]  = m_t[i];
      m_lapn[i] = (m_lapn[i] + 1) % 16;
      lv = 1;
      le.inst = 8'(i);
      le.tm   = fields(m_t[i], p_thz(i));
      lq.push_back(le);
    end
    if (run && en[i]) m_frac[i] = tick_now ? 0 : m_frac[i] + 1;
    if (tick_now) begin
      if (m_t[i] == maxt) sat = 1;
      else begin
        m_t[i] = m_t[i] + 1;
        tsub = 1;
        tsec = (m_t[i] % p_thz(i) == 0);
      end
    end
    if (prev == 1) begin
      if (sat) m_ovf[i] = 1;
      if (ss[i] || sat) m_mode[i] = 2;
    end else if (clr[i]) begin
      m_mode[i] = 0; m_t[i] = 0; m_frac[i] = 0; m_lapn[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
    end else if (ss[i] && !m_ovf[i]) begin
      m_mode[i] = 1;
    end
    s.run  = (m_mode[i] == 1);
    s.ovf  = m_ovf[i];
    s.tm   = fields(m_t[i], p_thz(i));
    s.tsub = tsub;
    s.tsec = tsec;
    s.lv   = lv;
    s.lcnt = 4'(m_lapn[i]);
    s.laps = fields(m_lap[i], p_thz(i));
    sq.push_back(s);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n cycles: predict each edge, then release the one-cycle pulses.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < N; i++) model_step(i);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        ss[i] = 1'b0; clr[i] = 1'b0; lp[i] = 1'b0;
      end
    end
  endtask

  // Monitor: compare each presented status and each lap_valid event.
  status_t act_s, exp_s;
  lap_t    act_l, exp_l;
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (sq.size() > 0) begin
        exp_s = sq.pop_front();
        act_s = {run_o[i], ovf_o[i], sub_o[i], sec_o[i], min_o[i], hr_o[i], tsub_o[i], tsec_o[i],
                 lv_o[i], lcnt_o[i], lsub_o[i], lsec_o[i], lmin_o[i], lhr_o[i]};
        n_chk++;
        if (act_s !== exp_s) begin
          n_fail++;
          $display("FAIL status inst%0d: got %h expected %h", i, act_s, exp_s);
        end
      end
      if (lv_o[i] === 1'b1) begin
        act_l = {8'(i), lsub_o[i], lsec_o[i], lmin_o[i], lhr_o[i]};
        n_chk++;
        if (lq.size() == 0) begin
          n_fail++;
          $display("FAIL lap_unexpected inst%0d: got %h expected none", i, act_l);
        end else begin
          exp_l = lq.pop_front();
          if (act_l !== exp_l) begin
            n_fail++;
            $display("FAIL lap inst%0d: got %h expected %h", i, act_l, exp_l);
          end
        end
        $display("lap inst%0d %h:%h:%h.%h count %0d", i, lhr_o[i], lmin_o[i], lsec_o[i], lsub_o[i], lcnt_o[i]);
      end
      if (tsub_o[i] === 1'b1) cnt_tsub[i]++;
      if (tsec_o[i] === 1'b1) cnt_tsec[i]++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of test expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; ss[i] = 1'b0; clr[i] = 1'b0; lp[i] = 1'b0;
      m_t[i] = 0; m_frac[i] = 0; m_mode[i] = 0; m_lapn[i] = 0; m_lap[i] = 0; m_ovf[i] = 1'b0;
      cnt_tsub[i] = 0; cnt_tsec[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset_running%0d", i), run_o[i], 0);
      chk($sformatf("reset_overflow%0d", i), ovf_o[i], 0);
      chk($sformatf("reset_time%0d", i), {sub_o[i], sec_o[i], min_o[i], hr_o[i]}, 0);
      chk($sformatf("reset_lap%0d", i), {lv_o[i], lcnt_o[i], lsub_o[i], lsec_o[i]}, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) en[i] = 1'b1;

    // One second of running: 100 sub ticks, one second tick.
    ss[0] = 1'b1; step(1);
    cnt_tsub[0] = 0; cnt_tsec[0] = 0;
    step(1000);
    chk("one_sec_seconds", sec_o[0], enc(1));
    chk("one_sec_sub", sub_o[0], enc(0));
    chk("one_sec_tick_sub_count", cnt_tsub[0], 100);
    chk("one_sec_tick_sec_count", cnt_tsec[0], 1);

    // Pause retains the prescaler fraction.
    step(25);
    ss[0] = 1'b1; step(1);
    step(500);
    ss[0] = 1'b1; step(1);
    step(5);
    chk("resume_sub", sub_o[0], enc(3));
    chk("resume_seconds", sec_o[0], enc(1));

    // Clear is ignored while running. Clear and start_stop in PAUSE yield IDLE.
    clr[0] = 1'b1; step(1);
    chk("clear_in_run_running", run_o[0], 1);
    chk("clear_in_run_sub", sub_o[0], enc(3));
    ss[0] = 1'b1; step(1);
    chk("paused_running", run_o[0], 0);
    ss[0] = 1'b1; clr[0] = 1'b1; step(1);
    chk("clear_wins_running", run_o[0], 0);
    chk("clear_wins_time", {sub_o[0], sec_o[0], min_o[0], hr_o[0]}, 0);
    chk("clear_wins_laps", lcnt_o[0], 0);

    // Lap on the 0:00:59.99 -> 0:01:00.00 tick (inst 2), saturation run (inst 1).
    ss[1] = 1'b1; ss[2] = 1'b1; step(1);
    step(11999);
    lp[2] = 1'b1; step(1);
    chk("lap_edge_valid", lv_o[2], 1);
    chk("lap_edge_sec", lsec_o[2], enc(59));
    chk("lap_edge_sub", lsub_o[2], enc(99));
    chk("lap_edge_min", lmin_o[2], 0);
    chk("lap_edge_count", lcnt_o[2], 1);
    chk("lap_edge_minutes", min_o[2], enc(1));
    for (int k = 0; k < 15; k++) begin
      lp[2] = 1'b1; step(1);
    end
    chk("lap_count_wrap", lcnt_o[2], 0);
    step(2385);
    chk("sat_running", run_o[1], 0);
    chk("sat_overflow", ovf_o[1], 1);
    chk("sat_time", {hr_o[1], min_o[1], sec_o[1], sub_o[1]}, {enc(1), enc(59), enc(59), enc(0)});
    ss[1] = 1'b1; step(1);
    chk("sat_restart_ignored", run_o[1], 0);
    step(3);
    clr[1] = 1'b1; step(1);
    chk("sat_clear_overflow", ovf_o[1], 0);
    chk("sat_clear_time", {hr_o[1], min_o[1], sec_o[1], sub_o[1]}, 0);

    // Randomised pulses and enable on all instances.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        en[i]  = ($urandom_range(7) != 0);
        ss[i]  = ($urandom_range(63) == 0);
        clr[i] = ($urandom_range(31) == 0);
        lp[i]  = ($urandom_range(15) == 0);
      end
      step(1);
    end

    chk("status_queue_drained", sq.size(), 0);
    chk("lap_queue_drained", lq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
